// File: rtl/parity_frame_ctrl_if.sv
// Handshake and serial-line bundle for the parity framing controller.
interface parity_frame_ctrl_if #(
    parameter int DATA_W = 8
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              x_out;
    logic              frame_act;
    logic              par_slot;
    logic              done;
    logic [7:0]        frames_sent;

    // Upstream word source / line observer side
    modport master (
        output in_valid, in_data,
        input  in_ready, x_out, frame_act, par_slot, done, frames_sent
    );

    // Framing controller side
    modport slave (
        input  in_valid, in_data,
        output in_ready, x_out, frame_act, par_slot, done, frames_sent
    );
endinterface

// File: rtl/parity_frame_ctrl.sv
// Serial framing controller: shifts an accepted word out MSB-first, appends
// the parity bit, then idles the line for GAP cycles before the next word.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | line low, in_ready high, waiting for in_valid
// S_DATA   | data bits on x_out, one per cycle, MSB first
// S_PARITY | parity bit on x_out, done pulse, frame counted
// S_GAP    | line low for GAP cycles (down-counter to zero)
module parity_frame_ctrl #(
    parameter int DATA_W = 8,
    parameter bit ODD    = 1'b0,
    parameter int GAP    = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    parity_frame_ctrl_if.slave bus
);

    localparam int                CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_W - 1);
    // GAP state is entered with GAP-1 so that it lasts exactly GAP cycles
    localparam logic [3:0]        GAP_LOAD = 4'((GAP > 0) ? GAP - 1 : 0);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_GAP} state_t;

    state_t             state_q, state_d;
    logic [DATA_W-1:0]  shift_q, shift_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               acc_q, acc_d;
    logic [3:0]         gap_q, gap_d;
    logic               x_q, x_d;
    logic               frame_act_q, frame_act_d;
    logic               par_slot_q, par_slot_d;
    logic               done_q, done_d;
    logic [7:0]         frames_q, frames_d;
    logic               accept;

    // in_ready is a pure state decode, forced low while reset is held
    assign bus.in_ready = (state_q == S_IDLE) && rst_n;
    assign accept       = bus.in_valid && (state_q == S_IDLE);

    assign bus.x_out       = x_q;
    assign bus.frame_act   = frame_act_q;
    assign bus.par_slot    = par_slot_q;
    assign bus.done        = done_q;
    assign bus.frames_sent = frames_q;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state decode
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (accept) state_d = S_DATA;
            S_DATA:   if (cnt_q == CNT_LAST) state_d = S_PARITY;
            S_PARITY: begin
                if (GAP > 0) state_d = S_GAP;
                else         state_d = S_IDLE;
            end
            S_GAP:    if (gap_q == 4'd0) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Datapath and registered-output next values
    always_comb begin
        shift_d     = shift_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        gap_d       = gap_q;
        x_d         = x_q;
        frame_act_d = frame_act_q;
        par_slot_d  = par_slot_q;
        done_d      = done_q;
        frames_d    = frames_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    shift_d     = bus.in_data;
                    acc_d       = ODD ^ bus.in_data[DATA_W-1];
                    cnt_d       = '0;
                    x_d         = bus.in_data[DATA_W-1];
                    frame_act_d = 1'b1;
                end
            end
            S_DATA: begin
                if (cnt_q != CNT_LAST) begin
                    // bit DATA_W-2 of the current shift value is the next bit out
                    shift_d = {shift_q[DATA_W-2:0], 1'b0};
                    x_d     = shift_q[DATA_W-2];
                    acc_d   = acc_q ^ shift_q[DATA_W-2];
                    cnt_d   = cnt_q + 1'b1;
                end else begin
                    // accumulator already holds ODD ^ (xor of all data bits)
                    x_d        = acc_q;
                    par_slot_d = 1'b1;
                    done_d     = 1'b1;
                    frames_d   = frames_q + 8'd1;
                end
            end
            S_PARITY: begin
                x_d         = 1'b0;
                frame_act_d = 1'b0;
                par_slot_d  = 1'b0;
                done_d      = 1'b0;
                gap_d       = GAP_LOAD;
            end
            S_GAP: begin
                if (gap_q != 4'd0) gap_d = gap_q - 4'd1;
            end
            default: begin
                x_d = 1'b0;
            end
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q     <= '0;
            cnt_q       <= '0;
            acc_q       <= 1'b0;
            gap_q       <= 4'd0;
            x_q         <= 1'b0;
            frame_act_q <= 1'b0;
            par_slot_q  <= 1'b0;
            done_q      <= 1'b0;
            frames_q    <= 8'd0;
        end else begin
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            gap_q       <= gap_d;
            x_q         <= x_d;
            frame_act_q <= frame_act_d;
            par_slot_q  <= par_slot_d;
            done_q      <= done_d;
            frames_q    <= frames_d;
        end
    end

endmodule
